perm_epoch_scheduler: RTL and testbench

Sequences the port-permutation datapath. Chooses one of the 24 ordered 3-of-4 lane-to-port mappings per epoch, either sequentially or by a pseudo-random walk. Presents the chosen mapping to the crossbar consumer over a valid/ready handshake and holds it stable for a programmable number of cycles. Sits between the control registers and the crossbar select logic.

---
 rtl/perm_epoch_scheduler_pkg.sv | 31 +++
 rtl/perm_epoch_scheduler_gen.sv | 51 +++++
 rtl/perm_epoch_scheduler.sv | 141 ++++++++++++++
 tb/tb_perm_epoch_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perm_epoch_scheduler_pkg.sv
// Shared types and constants for the permutation epoch scheduler and its mapping generator.
// Latency: n/a (types, constants and one pure LFSR step function).
// Backpressure: n/a.
package perm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_NEXT    = 2'd3
  } state_t;

  // Number of ordered 3-of-4 lane-to-port mappings.
  localparam int NUM_PERMS = 24;

  // Fibonacci taps for x^5 + x^3 + 1: feedback from bit 4 (x^5) and bit 2 (x^3).
  localparam logic [4:0] LFSR_TAPS = 5'b10100;

  typedef logic [1:0] lane_idx_t;

  // perm[i] is the port driven by lane i.
  typedef lane_idx_t [2:0] perm_t;

  // Selection-0 mapping: lane0=3, lane1=0, lane2=1.
  localparam perm_t PERM_RESET = {2'd1, 2'd0, 2'd3};

  function automatic logic [4:0] lfsr_next(input logic [4:0] v);
    return {v[3:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/perm_epoch_scheduler_gen.sv
// Maps a selection index to an ordered 3-of-4 lane-to-port permutation.
// Latency: combinational. Backpressure: none.
// Ports: selection (index in), permutation (lane0..2 port indices out); illegal indices give the selection-0 mapping.
module SafePermutationGenerator
  import perm_sched_pkg::*;
#(
  parameter int PERM_SIZE = 5
) (
  input  logic [PERM_SIZE-1:0] selection,
  output perm_t                permutation
);

  logic [4:0] sel5;
  logic [4:0] grp;
  logic [4:0] rem;
  lane_idx_t  lane0;
  lane_idx_t  idx1;
  lane_idx_t  r0, r1, r2;
  lane_idx_t  lo, hi;
  logic       odd;

  // Ordering: lane0 walks 3,2,1,0 in groups of six; within a group the two
  // remaining lanes take the leftover ports in lexicographic order.
  always_comb begin
    sel5  = 5'(selection);
    grp   = sel5 / 5'd6;
    rem   = sel5 % 5'd6;
    lane0 = lane_idx_t'(5'd3 - grp);
    idx1  = lane_idx_t'(rem >> 1);
    odd   = rem[0];

    // Leftover ports in ascending order once lane0's port is removed.
    r0 = (lane0 == 2'd0) ? 2'd1 : 2'd0;
    r1 = (lane0 <= 2'd1) ? 2'd2 : 2'd1;
    r2 = (lane0 <= 2'd2) ? 2'd3 : 2'd2;

    lo = 2'd0;
    hi = 2'd0;
    permutation = PERM_RESET;
    if (selection < PERM_SIZE'(NUM_PERMS)) begin
      case (idx1)
        2'd0:    begin permutation[1] = r0; lo = r1; hi = r2; end
        2'd1:    begin permutation[1] = r1; lo = r0; hi = r2; end
        default: begin permutation[1] = r2; lo = r0; hi = r1; end
      endcase
      permutation[0] = lane0;
      permutation[2] = odd ? hi : lo;
    end
  end

endmodule

// File: rtl/perm_epoch_scheduler.sv
// Per-epoch lane-to-port mapping scheduler (sequential or LFSR walk), offered to the crossbar over valid/ready.
// Latency: start -> valid 1 cycle; epoch end -> next valid 2 cycles (sequential) or 2+rejections (random); outputs registered.
// Backpressure: mapping held stable with valid high until perm_ready_i; the epoch timer only starts after the handshake.
// Ports: start_i/stop_i/mode_i/epoch_len_i control; perm_valid_o/perm_ready_i handshake;
//        perm_active_o, epoch_done_o status; selection_o/permutation_o current mapping.
module perm_epoch_scheduler
  import perm_sched_pkg::*;
#(
  parameter int         PERM_SIZE = 5,
  parameter int         NUM_PERMS = perm_sched_pkg::NUM_PERMS,
  parameter logic [4:0] LFSR_SEED = 5'h01
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 mode_i,
  input  logic [7:0]           epoch_len_i,
  output logic                 perm_valid_o,
  input  logic                 perm_ready_i,
  output logic                 perm_active_o,
  output logic                 epoch_done_o,
  output logic [PERM_SIZE-1:0] selection_o,
  output perm_t                permutation_o
);

  localparam logic [PERM_SIZE-1:0] SEL_LAST = PERM_SIZE'(NUM_PERMS - 1);
  localparam logic [4:0]           LFSR_MAX = 5'(NUM_PERMS);

  state_t               state;
  logic [PERM_SIZE-1:0] seq_cnt;
  logic [PERM_SIZE-1:0] cand_sel;
  logic [PERM_SIZE-1:0] sel_inc;
  logic [4:0]           lfsr;
  logic [4:0]           lfsr_step;
  logic                 lfsr_ok;
  logic                 step_ok;
  logic                 mode;
  logic [7:0]           epoch_cnt;
  logic [7:0]           epoch_load;
  perm_t                cand_perm;

  // Candidate selection: IDLE offers the current value without advancing,
  // NEXT offers the advanced value. The random candidate is lfsr-1, legal
  // only while lfsr is in 1..NUM_PERMS.
  always_comb begin
    lfsr_step  = lfsr_next(lfsr);
    lfsr_ok    = (lfsr != 5'd0) && (lfsr <= LFSR_MAX);
    step_ok    = (lfsr_step != 5'd0) && (lfsr_step <= LFSR_MAX);
    sel_inc    = (selection_o >= SEL_LAST) ? '0 : selection_o + 1'b1;
    epoch_load = (epoch_len_i == 8'd0) ? 8'd1 : epoch_len_i;
    cand_sel   = selection_o;
    case (state)
      ST_IDLE: cand_sel = mode_i ? PERM_SIZE'(lfsr - 5'd1) : seq_cnt;
      ST_NEXT: cand_sel = mode ? PERM_SIZE'(lfsr_step - 5'd1) : sel_inc;
      default: cand_sel = selection_o;
    endcase
  end

  SafePermutationGenerator #(
    .PERM_SIZE (PERM_SIZE)
  ) u_gen (
    .selection   (cand_sel),
    .permutation (cand_perm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      perm_valid_o  <= 1'b0;
      perm_active_o <= 1'b0;
      epoch_done_o  <= 1'b0;
      selection_o   <= '0;
      permutation_o <= PERM_RESET;
      seq_cnt       <= '0;
      lfsr          <= LFSR_SEED;
      mode          <= 1'b0;
      epoch_cnt     <= 8'd0;
    end else begin
      epoch_done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          mode <= mode_i;
          if (start_i) begin
            // An out-of-range seed must not be offered; walk to a legal value first.
            if (mode_i && !lfsr_ok) begin
              state <= ST_NEXT;
            end else begin
              state         <= ST_PRESENT;
              perm_valid_o  <= 1'b1;
              selection_o   <= cand_sel;
              permutation_o <= cand_perm;
            end
          end
        end
        ST_PRESENT: begin
          if (perm_ready_i) begin
            state         <= ST_ACTIVE;
            perm_valid_o  <= 1'b0;
            perm_active_o <= 1'b1;
            epoch_cnt     <= epoch_load;
            // Registered pulse must coincide with the cycle the counter reads 1.
            epoch_done_o  <= (epoch_load == 8'd1);
          end
        end
        ST_ACTIVE: begin
          epoch_cnt <= epoch_cnt - 8'd1;
          if (epoch_cnt == 8'd2) epoch_done_o <= 1'b1;
          if (epoch_cnt == 8'd1) begin
            perm_active_o <= 1'b0;
            if (stop_i) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_NEXT;
              mode  <= mode_i;
            end
          end
        end
        ST_NEXT: begin
          if (!mode) begin
            seq_cnt       <= sel_inc;
            state         <= ST_PRESENT;
            perm_valid_o  <= 1'b1;
            selection_o   <= cand_sel;
            permutation_o <= cand_perm;
          end else begin
            lfsr <= lfsr_step;
            if (step_ok) begin
              state         <= ST_PRESENT;
              perm_valid_o  <= 1'b1;
              selection_o   <= cand_sel;
              permutation_o <= cand_perm;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perm_epoch_scheduler.sv
// Bench for perm_epoch_scheduler: event-level protocol model plus directed scenarios.
// Latency: n/a. Backpressure: exercised by holding perm_ready_i low.
module tb_perm_epoch_scheduler;
  import perm_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] epoch_len = 8'd3;
  logic       valid, active, done;
  logic [4:0] sel;
  perm_t      perm;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  perm_t tbl [24];

  perm_epoch_scheduler #(
    .PERM_SIZE (5),
    .NUM_PERMS (24),
    .LFSR_SEED (5'h01)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .stop_i        (stop),
    .mode_i        (mode),
    .epoch_len_i   (epoch_len),
    .perm_valid_o  (valid),
    .perm_ready_i  (ready),
    .perm_active_o (active),
    .epoch_done_o  (done),
    .selection_o   (sel),
    .permutation_o (perm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_offer_at = -1;
  int m_act_start = -1;
  int m_act_end = -1;
  bit m_offering = 1'b0;
  int m_cur = 0;
  int m_seq = 0;
  int m_lfsr = 1;

  function automatic int lfsr_adv(input int v);
    return ((v << 1) & 31) | (((v >> 4) ^ (v >> 2)) & 1);
  endfunction

  // Walk the LFSR until it lands in 1..24; the number of steps is the NEXT duration.
  function automatic int seek_len();
    int k = 0;
    do begin
      m_lfsr = lfsr_adv(m_lfsr);
      k++;
    end while (m_lfsr > 24 || m_lfsr == 0);
    m_cur = m_lfsr - 1;
    return k;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_perm", 32'(perm), 32'({2'd1, 2'd0, 2'd3}));
      m_offer_at = -1; m_act_start = -1; m_act_end = -1;
      m_offering = 1'b0; m_cur = 0; m_seq = 0; m_lfsr = 1;
    end else begin
      if (cyc == m_offer_at) begin
        m_offering = 1'b1;
        m_offer_at = -1;
      end
      chk("m_valid", 32'(valid), 32'(m_offering));
      chk("m_active", 32'(active), 32'(cyc >= m_act_start && cyc <= m_act_end));
      chk("m_done", 32'(done), 32'(cyc == m_act_end));
      if (m_offering) begin
        chk("m_sel", 32'(sel), 32'(m_cur));
        chk("m_perm", 32'(perm), 32'(tbl[m_cur]));
      end
      // advance using this cycle's inputs
      if (m_offering && ready) begin
        m_offering  = 1'b0;
        m_act_start = cyc + 1;
        m_act_end   = cyc + ((epoch_len == 0) ? 1 : int'(epoch_len));
      end else if (!m_offering && m_offer_at < 0 && cyc > m_act_end && start) begin
        if (!mode) begin
          m_cur = m_seq;
          m_offer_at = cyc + 1;
        end else if (m_lfsr >= 1 && m_lfsr <= 24) begin
          m_cur = m_lfsr - 1;
          m_offer_at = cyc + 1;
        end else begin
          m_offer_at = cyc + 1 + seek_len();
        end
      end else if (cyc == m_act_end && !stop) begin
        if (!mode) begin
          m_cur = (m_cur + 1) % 24;
          m_seq = m_cur;
          m_offer_at = cyc + 2;
        end else begin
          m_offer_at = cyc + 1 + seek_len();
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for an offered mapping, counting active cycles and done pulses seen on the way.
  task automatic wait_offer(output int s, output int p, output int at, output int na, output int nd);
    s = 0; p = 0; at = -1; na = 0; nd = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (active === 1'b1) na++;
      if (done === 1'b1) nd++;
      if (valid === 1'b1) begin
        s = int'(sel); p = int'(perm); at = cyc;
        return;
      end
    end
    chk("offer_timeout", 32'd0, 32'd1);
  endtask

  int s, p, at, na, nd, t0, prev_at, p23, dups, max_next, nv;
  int rs [25];
  int rat [25];

  initial begin
    automatic int n = 0;
    for (int a = 3; a >= 0; a--)
      for (int b = 0; b < 4; b++)
        if (b != a)
          for (int c = 0; c < 4; c++)
            if (c != a && c != b) begin
              tbl[n] = {2'(c), 2'(b), 2'(a)};
              n++;
            end
    chk("tbl_sel0", 32'(tbl[0]), 32'({2'd1, 2'd0, 2'd3}));
    chk("tbl_sel1", 32'(tbl[1]), 32'({2'd2, 2'd0, 2'd3}));
    chk("tbl_sel23", 32'(tbl[23]), 32'({2'd2, 2'd3, 2'd0}));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Sequential stepping, epoch length 3
    mode = 1'b0; epoch_len = 8'd3; ready = 1'b1;
    tick(); start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    wait_offer(s, p, at, na, nd);
    chk("start_latency", 32'(at - t0), 32'd1);
    chk("seq_first_sel", 32'(s), 32'd0);
    chk("seq_first_perm", 32'(p), 32'({2'd1, 2'd0, 2'd3}));
    prev_at = at;
    wait_offer(s, p, at, na, nd);
    chk("seq_active_cycles", 32'(na), 32'd3);
    chk("seq_done_pulses", 32'(nd), 32'd1);
    chk("seq_second_sel", 32'(s), 32'd1);
    chk("seq_second_perm", 32'(p), 32'({2'd2, 2'd0, 2'd3}));
    chk("seq_offer_spacing", 32'(at - prev_at), 32'd5);

    // Wrap 23 -> 0
    for (int i = 0; i < 22; i++) wait_offer(s, p, at, na, nd);
    chk("wrap_sel23", 32'(s), 32'd23);
    p23 = p;
    chk("wrap_perm23", 32'(p23), 32'({2'd2, 2'd3, 2'd0}));
    wait_offer(s, p, at, na, nd);
    chk("wrap_sel0", 32'(s), 32'd0);
    chk("wrap_perm0", 32'(p), 32'({2'd1, 2'd0, 2'd3}));

    // Backpressure: ready low for 5 offered cycles, accepted on the 6th
    tick(); ready = 1'b0;
    wait_offer(s, p, at, na, nd);
    chk("bp_sel", 32'(s), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(valid), 32'd1);
      chk("bp_hold_sel", 32'(sel), 32'(s));
      chk("bp_hold_perm", 32'(perm), 32'(p));
    end
    tick(); ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_valid", 32'(valid), 32'd1);
    @(negedge clk);
    chk("bp_active_next", 32'(active), 32'd1);
    chk("bp_valid_drop", 32'(valid), 32'd0);

    // Reset in the middle of an active epoch
    tick(); rst_n = 1'b0;
    #1;
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_perm", 32'(perm), 32'({2'd1, 2'd0, 2'd3}));
    repeat (2) tick();
    rst_n = 1'b1;

    // Random mode, seed 1, 25 epochs
    mode = 1'b1; epoch_len = 8'd2; ready = 1'b1;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      wait_offer(s, p, at, na, nd);
      rs[i] = s; rat[i] = at;
    end
    chk("rnd_first_sel", 32'(rs[0]), 32'd0);
    dups = 0;
    for (int i = 0; i < 24; i++)
      for (int j = 0; j < i; j++)
        if (rs[i] == rs[j]) dups++;
    chk("rnd_distinct24", 32'(dups), 32'd0);
    chk("rnd_25th_eq_1st", 32'(rs[24]), 32'(rs[0]));
    max_next = 0;
    // offer spacing = 1 handshake + 2 active + NEXT cycles
    for (int i = 1; i < 25; i++)
      if (rat[i] - rat[i-1] - 3 > max_next) max_next = rat[i] - rat[i-1] - 3;
    chk("rnd_next_le8", 32'(max_next <= 8 && max_next >= 1), 32'd1);

    // Stop mid-epoch: epoch completes, then nothing further is offered
    tick(); stop = 1'b1;
    na = 0; nd = 0; nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (active === 1'b1) na++;
      if (done === 1'b1) nd++;
      if (valid === 1'b1) nv++;
    end
    chk("stop_active_left", 32'(na), 32'd2);
    chk("stop_done_once", 32'(nd), 32'd1);
    chk("stop_no_valid", 32'(nv), 32'd0);
    stop = 1'b0;

    // Zero epoch length behaves as one cycle
    mode = 1'b0; epoch_len = 8'd0;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    wait_offer(s, p, at, na, nd);
    chk("zero_first_sel", 32'(s), 32'd0);
    wait_offer(s, p, at, na, nd);
    chk("zero_active_cycles", 32'(na), 32'd1);
    chk("zero_done_pulses", 32'(nd), 32'd1);
    chk("zero_next_sel", 32'(s), 32'd1);
    tick(); stop = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
